// File: rtl/volatility_feeder.sv
// Top-of-book sample feeder for the volatility stage.
// Merges partial bid/ask updates into a per-stock book, assigns each
// non-empty sample a slot in that stock's circular window and emits it.
//
// Ports:
//   i_clk, i_reset_n           clock, synchronous active-low reset
//   i_upd_*                    top-of-book update (valid/ready, per-side enables)
//   i_flush, i_flush_stock_id  clear one stock's book and window pointer
//   o_upd_ready                high whenever out of reset (one update per cycle)
//   o_valid, o_write_address,
//   o_best_bid/ask, o_stock_id sample strobe and payload (held between strobes)
//   o_buffer_size(_reciprocal) window length and its Q32.32 reciprocal
//   o_drop                     pulse when an accepted update produced no sample
module volatility_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int BUFFER_SIZE  = 32,
  parameter int NUM_STOCKS   = 4
) (
  input  logic                                      i_clk,
  input  logic                                      i_reset_n,
  input  logic                                      i_upd_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0]             i_upd_stock_id,
  input  logic                                      i_upd_bid_en,
  input  logic [DATA_WIDTH-1:0]                     i_upd_bid,
  input  logic                                      i_upd_ask_en,
  input  logic [DATA_WIDTH-1:0]                     i_upd_ask,
  input  logic                                      i_flush,
  input  logic [$clog2(NUM_STOCKS)-1:0]             i_flush_stock_id,
  output logic                                      o_upd_ready,
  output logic                                      o_valid,
  output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_write_address,
  output logic [DATA_WIDTH-1:0]                     o_best_bid,
  output logic [DATA_WIDTH-1:0]                     o_best_ask,
  output logic [$clog2(NUM_STOCKS)-1:0]             o_stock_id,
  output logic [DATA_WIDTH-1:0]                     o_buffer_size,
  output logic [FP_WORD_SIZE-1:0]                   o_buffer_size_reciprocal,
  output logic                                      o_drop
);

  localparam int SW = $clog2(NUM_STOCKS);
  localparam int PW = $clog2(BUFFER_SIZE);

  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [FP_WORD_SIZE-1:0] RECIP =
    FP_WORD_SIZE'(64'h1_0000_0000 / 64'(BUFFER_SIZE));

  logic [DATA_WIDTH-1:0] bid_reg [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] ask_reg [NUM_STOCKS];
  logic [PW-1:0]         wr_ptr  [NUM_STOCKS];

  logic                  accept;
  logic                  no_en;
  logic                  flush_hit;
  logic                  write_book;
  logic                  emit;
  logic                  drop_now;
  logic [DATA_WIDTH-1:0] merged_bid;
  logic [DATA_WIDTH-1:0] merged_ask;

  assign o_upd_ready              = i_reset_n;
  assign o_buffer_size            = DATA_WIDTH'(BUFFER_SIZE);
  assign o_buffer_size_reciprocal = RECIP;

  // The book registers are written at the accepting edge, so a following
  // update to the same stock already reads the merged values here; no
  // separate bypass path is needed for back-to-back traffic.
  always_comb begin
    accept     = i_upd_valid && o_upd_ready;
    merged_bid = i_upd_bid_en ? i_upd_bid : bid_reg[i_upd_stock_id];
    merged_ask = i_upd_ask_en ? i_upd_ask : ask_reg[i_upd_stock_id];
    no_en      = !i_upd_bid_en && !i_upd_ask_en;
    flush_hit  = i_flush && (i_flush_stock_id == i_upd_stock_id);
    // A colliding flush wins and the update is thrown away entirely.
    write_book = accept && !flush_hit && !no_en;
    // An empty book is still recorded but never becomes a sample.
    emit       = write_book && ((merged_bid != '0) || (merged_ask != '0));
    drop_now   = accept && !emit;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_STOCKS; s++) begin
        bid_reg[s] <= '0;
        ask_reg[s] <= '0;
        wr_ptr[s]  <= '0;
      end
      o_valid         <= 1'b0;
      o_drop          <= 1'b0;
      o_write_address <= '0;
      o_best_bid      <= '0;
      o_best_ask      <= '0;
      o_stock_id      <= '0;
    end else begin
      o_valid <= emit;
      o_drop  <= drop_now;
      if (write_book) begin
        bid_reg[i_upd_stock_id] <= merged_bid;
        ask_reg[i_upd_stock_id] <= merged_ask;
      end
      if (emit) begin
        // Power-of-two sizes make {stock, ptr} == stock*BUFFER_SIZE + ptr,
        // and the pointer wraps by plain overflow.
        wr_ptr[i_upd_stock_id] <= wr_ptr[i_upd_stock_id] + PTR_ONE;
        o_write_address        <= {i_upd_stock_id, wr_ptr[i_upd_stock_id]};
        o_best_bid             <= merged_bid;
        o_best_ask             <= merged_ask;
        o_stock_id             <= i_upd_stock_id;
      end
      // Placed last so it overrides any same-stock write above.
      if (i_flush) begin
        bid_reg[i_flush_stock_id] <= '0;
        ask_reg[i_flush_stock_id] <= '0;
        wr_ptr[i_flush_stock_id]  <= '0;
      end
    end
  end

endmodule
